// File: rtl/muldiv_pkg.sv
// Shared ALU opcodes, mul/div FSM states and iteration count.
// Optional single-cycle multiply: define MULDIV_FAST_MUL_EN.
package muldiv_pkg;

  localparam logic [4:0] ALUOP_MULT  = 5'd10;
  localparam logic [4:0] ALUOP_MULTU = 5'd11;
  localparam logic [4:0] ALUOP_DIV   = 5'd12;
  localparam logic [4:0] ALUOP_DIVU  = 5'd13;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_e;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-divide step: compare shifted remainder to divisor,
// subtract when it fits and emit the quotient bit.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    diff  = rem_i - {1'b0, div_i};
    ge    = rem_i >= {1'b0, div_i};
    q_o   = ge;
    rem_o = ge ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit, {hi,lo} result.
// MULDIV_FAST_MUL_EN selects a single-cycle native multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [4:0]         ALU_control_i,
  input  logic [WIDTH-1:0]   src0_i,
  input  logic [WIDTH-1:0]   src1_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] result_o
);

  md_state_e          state_q;
  logic [4:0]         cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               div_q;
  logic               negl_q;
  logic               negh_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;

  logic               is_mul;
  logic               is_div;
  logic               is_sgn;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  always_comb begin
    is_mul = (ALU_control_i == ALUOP_MULT) ||
             (ALU_control_i == ALUOP_MULTU);
    is_div = (ALU_control_i == ALUOP_DIV) ||
             (ALU_control_i == ALUOP_DIVU);
    is_sgn = (ALU_control_i == ALUOP_MULT) ||
             (ALU_control_i == ALUOP_DIV);
    sa     = is_sgn & src0_i[WIDTH-1];
    sb     = is_sgn & src1_i[WIDTH-1];
    abs_a  = sa ? -src0_i : src0_i;
    abs_b  = sb ? -src1_i : src1_i;
  end

  // acc_q holds {partial product, multiplier} or {remainder, dividend}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    div_nxt = {step_rem, acc_q[WIDTH-2:0], step_q};
  end

  muldiv_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (acc_q[2*WIDTH-1:WIDTH-1]),
    .div_i (opnd_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  logic [WIDTH-1:0]   hi_f;
  logic [WIDTH-1:0]   lo_f;
  logic [2*WIDTH-1:0] fix_res;

  always_comb begin
    hi_f = acc_q[2*WIDTH-1:WIDTH];
    lo_f = acc_q[WIDTH-1:0];
    if (negh_q) hi_f = -hi_f;
    if (negl_q) lo_f = -lo_f;
    if (dz_q)   lo_f = '1;
    if (div_q) fix_res = {hi_f, lo_f};
    else       fix_res = negl_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      negl_q   <= 1'b0;
      negh_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MD_IDLE: begin
          if (start_i && (is_mul || is_div)) begin
            acc_q   <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
            opnd_q  <= is_div ? abs_b : abs_a;
            div_q   <= is_div;
            negl_q  <= sa ^ sb;
            negh_q  <= sa;
            dz_q    <= is_div && (src1_i == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MD_CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (is_mul) begin
              acc_q   <= (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
              state_q <= MD_FIX;
            end
`endif
          end
        end
        MD_CALC: begin
          acc_q <= div_q ? div_nxt : mul_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(MD_ITERS - 1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule
